// File: rtl/mem_responder.sv
// Word-addressed 16-bit memory slave with fixed, parameterised response latency.
// Optional MEM_STATS_EN adds saturating read/write completion counters.
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        mem_err
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 accept, access;

    logic                 op_write_q, op_err_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [15:0]          wdata_q;
    logic [1:0]           be_q;

    logic                 acc_write;
    logic [ADDR_BITS-1:0] acc_idx;
    logic [15:0]          acc_wdata;
    logic [1:0]           acc_be;

    logic [15:0]          mem_array [DEPTH];

    logic                 req;
    logic                 unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens at the accepting edge, so it must use the live bus.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write = mem_write;
            acc_idx   = mem_address[ADDR_BITS:1];
            acc_wdata = mem_wdata;
            acc_be    = mem_byte_enable;
        end else begin
            acc_write = op_write_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            mem_rdata <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access && !acc_write) begin
                mem_rdata <= mem_array[acc_idx];
            end
        end
    end

    // Request capture; contents only matter once a request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write_q <= mem_write;
            op_err_q   <= mem_read & mem_write;
            idx_q      <= mem_address[ADDR_BITS:1];
            wdata_q    <= mem_wdata;
            be_q       <= mem_byte_enable;
        end
    end

    // NOTE: the storage array has no reset; contents survive rst_n, but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && access && acc_write) begin
            if (acc_be[0]) mem_array[acc_idx][7:0]  <= acc_wdata[7:0];
            if (acc_be[1]) mem_array[acc_idx][15:8] <= acc_wdata[15:8];
        end
    end

    assign mem_resp = (state_q == RESP);
    assign mem_err  = (state_q == RESP) & op_err_q;

`ifdef MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else if (access) begin
            if (acc_write) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=4 instance driven from a vector table
// plus hand sequences, and a LATENCY=1 instance for back-to-back spacing.
module tb_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic        scr;
    } vec_t;

    typedef struct {
        logic        is_write;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp, mem_err;
    logic [15:0] mem_rdata;

    logic        l1_read, l1_write;
    logic [1:0]  l1_be;
    logic [15:0] l1_address, l1_wdata;
    logic        l1_resp, l1_err;
    logic [15:0] l1_rdata;

`ifdef MEM_STATS_EN
    logic [15:0] rd_count, wr_count, l1_rd_count, l1_wr_count;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    vec_t vecs[13];

    mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .mem_err         (mem_err)
`ifdef MEM_STATS_EN
        ,
        .rd_count        (rd_count),
        .wr_count        (wr_count)
`endif
    );

    mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (l1_read),
        .mem_write       (l1_write),
        .mem_byte_enable (l1_be),
        .mem_address     (l1_address),
        .mem_wdata       (l1_wdata),
        .mem_resp        (l1_resp),
        .mem_rdata       (l1_rdata),
        .mem_err         (l1_err)
`ifdef MEM_STATS_EN
        ,
        .rd_count        (l1_rd_count),
        .wr_count        (l1_wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required to finish before 500000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be,
                                input logic [15:0] exp_rdata, input logic exp_err,
                                input logic scr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.scr = scr;
        return v;
    endfunction

    // Drives one request at a negedge, expects mem_resp exactly LAT cycles later,
    // then drops the request and checks the pulse ends and mem_rdata holds.
    task automatic do_txn(input vec_t v, input string name);
        int   n;
        logic seen;
        exp_t e;
        mem_read        = v.rd;
        mem_write       = v.wr;
        mem_address     = v.addr;
        mem_wdata       = v.wdata;
        mem_byte_enable = v.be;
        sb.push_back('{is_write: v.wr, rdata: v.exp_rdata, err: v.exp_err});
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LAT + 4) begin
            @(negedge clk);
            n++;
            if (mem_resp) begin
                seen = 1'b1;
            end else if (v.scr && n == 1) begin
                mem_address     = v.addr ^ 16'h00F0;
                mem_wdata       = ~v.wdata;
                mem_byte_enable = ~v.be;
            end
        end
        e = sb.pop_front();
        check({name, " resp_seen"}, 32'(seen), 32'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!seen) return;
        check({name, " latency"}, 32'(n), 32'(LAT));
        check({name, " rdata"}, 32'(mem_rdata), 32'(e.rdata));
        check({name, " err"}, 32'(mem_err), 32'(e.err));
        @(negedge clk);
        check({name, " pulse_end"}, 32'({mem_resp, mem_err}), 32'd0);
        check({name, " rdata_hold"}, 32'(mem_rdata), 32'(e.rdata));
    endtask

    task automatic count_resp(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mem_resp) cnt++;
        end
    endtask

    initial begin
        int cnt;
        int total;

        // rd wr addr wdata be exp_rdata exp_err scramble
        vecs[0]  = mk(0, 1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 0, 16'h0010, 16'h0000, 2'b11, 16'hBEEF, 0, 0);
        vecs[2]  = mk(0, 1, 16'h0020, 16'h1234, 2'b11, 16'hBEEF, 0, 0);
        vecs[3]  = mk(0, 1, 16'h0020, 16'hAB00, 2'b10, 16'hBEEF, 0, 0);
        vecs[4]  = mk(1, 0, 16'h0020, 16'h0000, 2'b11, 16'hAB34, 0, 0);
        vecs[5]  = mk(0, 1, 16'h0020, 16'h00CD, 2'b01, 16'hAB34, 0, 0);
        vecs[6]  = mk(1, 0, 16'h0021, 16'h0000, 2'b11, 16'hABCD, 0, 0);
        vecs[7]  = mk(0, 1, 16'h0030, 16'h5555, 2'b11, 16'hABCD, 0, 0);
        vecs[8]  = mk(0, 1, 16'h0040, 16'h1111, 2'b11, 16'hABCD, 0, 0);
        vecs[9]  = mk(0, 1, 16'h0040, 16'h9999, 2'b00, 16'hABCD, 0, 0);
        vecs[10] = mk(1, 0, 16'h0040, 16'h0000, 2'b11, 16'h1111, 0, 0);
        vecs[11] = mk(0, 1, 16'h0050, 16'h4242, 2'b11, 16'h1111, 0, 1);
        vecs[12] = mk(1, 0, 16'h0050, 16'h0000, 2'b11, 16'h4242, 0, 1);

        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
        mem_address = 16'h0000; mem_wdata = 16'h0000;
        l1_read = 1'b0; l1_write = 1'b0; l1_be = 2'b00;
        l1_address = 16'h0000; l1_wdata = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset resp", 32'(mem_resp), 32'd0);
        check("reset rdata", 32'(mem_rdata), 32'd0);
        check("reset err", 32'(mem_err), 32'd0);
`ifdef MEM_STATS_EN
        check("reset counts", 32'({rd_count, wr_count}), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: read dropped after 2 cycles, write dropped mid-BUSY.
        mem_read = 1'b1; mem_address = 16'h0010;
        count_resp(2, cnt);
        total = cnt;
        mem_read = 1'b0;
        count_resp(1, cnt);
        total += cnt;
        mem_write = 1'b1; mem_address = 16'h0010; mem_wdata = 16'h0000; mem_byte_enable = 2'b11;
        count_resp(2, cnt);
        total += cnt;
        mem_write = 1'b0;
        count_resp(LAT + 2, cnt);
        total += cnt;
        check("abort no_resp", 32'(total), 32'd0);
        do_txn(mk(1, 0, 16'h0010, 16'h0000, 2'b11, 16'hBEEF, 0, 0), "abort readback");

        // Reset mid-BUSY during a write over 16'h5555.
        mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'h0000; mem_byte_enable = 2'b11;
        count_resp(2, cnt);
        total = cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy resp", 32'(mem_resp), 32'd0);
        check("rst_busy rdata", 32'(mem_rdata), 32'd0);
        rst_n = 1'b1;
        mem_write = 1'b0;
        count_resp(LAT + 2, cnt);
        total += cnt;
        check("rst_busy no_resp", 32'(total), 32'd0);

        // Conflict and aliasing: 16'h0202 maps to the same word as 16'h0002.
        do_txn(mk(1, 1, 16'h0202, 16'h7777, 2'b11, 16'h0000, 1, 0), "conflict");
        do_txn(mk(1, 0, 16'h0002, 16'h0000, 2'b11, 16'h7777, 0, 0), "alias read");
`ifdef MEM_STATS_EN
        check("stats wr_count", 32'(wr_count), 32'd1);
        check("stats rd_count", 32'(rd_count), 32'd1);
`endif
        do_txn(mk(1, 0, 16'h0030, 16'h0000, 2'b11, 16'h5555, 0, 0), "rst_busy readback");

        // LATENCY=1: write then read, then a held read must pulse every other cycle.
        l1_write = 1'b1; l1_address = 16'h0004; l1_wdata = 16'h3C3C; l1_be = 2'b11;
        @(negedge clk);
        check("l1 write resp", 32'(l1_resp), 32'd1);
        l1_write = 1'b0;
        @(negedge clk);
        check("l1 write pulse_end", 32'(l1_resp), 32'd0);
        l1_read = 1'b1;
        @(negedge clk);
        check("l1 read resp", 32'(l1_resp), 32'd1);
        check("l1 read rdata", 32'(l1_rdata), 32'h3C3C);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("l1 b2b cycle%0d", i), 32'(l1_resp), 32'((i % 2) == 0));
        end
        l1_read = 1'b0;
        @(negedge clk);
        check("l1 b2b end", 32'(l1_resp), 32'd0);
        check("l1 rdata hold", 32'(l1_rdata), 32'h3C3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory slave that answers the LC-3b datapath/control memory interface: mem_read/mem_write in, mem_resp out, with mem_address, mem_wdata and mem_rdata.
- Backed by an internal 16-bit-wide storage array with a parameterised, fixed response latency.
- Used as the memory model in CPU simulation and as the back-end for later cache work.
- Sits on the opposite side of the bus from the datapath MAR/MDR.

Parameters:
- ADDR_BITS, 8, number of word-address bits; the array holds 2**ADDR_BITS 16-bit words.
- LATENCY, 4, cycles from first request cycle to the mem_resp cycle; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- mem_read  input  1  read request, held high until mem_resp.
- mem_write  input  1  write request, held high until mem_resp.
- mem_byte_enable  input  2  write byte lanes: bit0 = [7:0], bit1 = [15:8].
- mem_address  input  16  byte address; bit 0 ignored, bits [ADDR_BITS:1] form the word index, higher bits alias.
- mem_wdata  input  16  write data.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  16  read data, valid during mem_resp and held until the next read completes.
- mem_err  output  1  one-cycle pulse, coincident with mem_resp, when mem_read and mem_write were both high at acceptance.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; mem_resp=0, mem_rdata=16'h0000, mem_err=0, counter=0.
  - The array is not cleared.
  - Reset during BUSY aborts the access with no array write.
- FSM states: IDLE, BUSY, RESP.
- IDLE: on an edge with mem_read|mem_write high, latch the op, word index, wdata and byte_enable.
  - LATENCY=1: go to RESP.
  - Otherwise: go to BUSY with counter=LATENCY-2.
- BUSY:
  - Counter nonzero: decrement.
  - Counter zero: perform the access at that edge and go to RESP.
  - If both mem_read and mem_write are low at any BUSY edge: abort, return to IDLE, no write, no resp.
- Access at the edge entering RESP:
  - Write: update only the enabled byte lanes.
  - Read: load the full word into mem_rdata.
- RESP: mem_resp=1 for exactly this cycle; unconditionally return to IDLE. A request still high in this cycle is not sampled.
- Timing: request first high in cycle t gives mem_resp high in cycle t+LATENCY.
- Back-to-back: a request in the cycle after RESP is a new transaction. Minimum transaction spacing is LATENCY+1 cycles.
- Simultaneous read and write at acceptance: treated as a write, mem_rdata unchanged, mem_err pulses with mem_resp.
- Latched values: address, wdata and byte_enable are latched at acceptance; later changes during BUSY are ignored.
- Write with mem_byte_enable=2'b00: completes normally with mem_resp, array unchanged.
- mem_rdata changes only at read completion or reset.

Optional Feature:
- Macro: MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0], both reset to 0.
  - Each increments at the edge entering RESP for a completed read or write, respectively; a conflicted request counts as a write.
  - Both saturate at 16'hFFFF; aborted requests are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Write then read: LATENCY=4; write addr 16'h0010, data 16'hBEEF, be=2'b11.
  - mem_resp is high exactly 4 cycles after the request; drop the request.
  - Then read 16'h0010: mem_resp at +4, mem_rdata=16'hBEEF, and mem_rdata holds after the request drops.
- Byte lanes: word 16'h1234 at 16'h0020; write 16'hAB00 with be=2'b10 and read it back, expect 16'hAB34.
  - Then write 16'h00CD with be=2'b01 and read it back, expect 16'hABCD.
- Abort: read issued, dropped after 2 cycles; then a write issued, dropped mid-BUSY.
  - Expect no mem_resp for either, array unchanged.
  - The next read completes normally at +LATENCY.
- Reset mid-BUSY: rst_n low for 1 cycle during a write to 16'h0030 (old value 16'h5555).
  - mem_resp stays 0, mem_rdata=0.
  - A subsequent read returns 16'h5555.
- Conflict and alias (ADDR_BITS=8): read and write both high, addr 16'h0202, data 16'h7777.
  - Expect mem_resp and mem_err together at +LATENCY.
  - Read of 16'h0002 returns 16'h7777 (aliasing); with MEM_STATS_EN, wr_count=1 and rd_count=1.
- LATENCY=1 back-to-back: hold mem_read high across the RESP cycle and into the next.
  - Expect mem_resp pulses spaced exactly 2 cycles apart, never on adjacent cycles.
